bitorder_in: RTL
================

BITORDER_IN -- requirements
Module: bitorder_in

Interface
REQ-001 SHALL have parameter IDLE_GAP, default 4: consecutive invalid cycles that close a frame (legal range 2..15).
REQ-002 SHALL have parameter MAX_BYTES, default 1522: maximum bytes emitted per frame.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port axiiv, input, 1: dibit valid.
REQ-006 SHALL have port axiid, input, 2: receive dibit, LSB-first within each byte.
REQ-007 SHALL have port axiov, output, 1: assembled-byte valid, a one-cycle pulse per byte.
REQ-008 SHALL have port axiod, output, 8: assembled byte.
REQ-009 SHALL have port frame_done, output, 1: one-cycle pulse when a frame closes.
REQ-010 SHALL have port err, output, 1: one-cycle pulse, coincident with frame_done, when the frame was malformed.

Function
REQ-011 SHALL assemble the four valid dibits d0..d3, in arrival order, into axiod = {d3,d2,d1,d0}.
REQ-012 SHALL assert axiov for exactly one cycle, on the cycle after the fourth valid dibit is sampled; axiod SHALL hold its value until the next byte.
REQ-013 SHALL treat axiiv low as a stall: partial dibits and the dibit count are retained, and assembly resumes on the next valid dibit.
REQ-014 SHALL close the frame when axiiv has been low for IDLE_GAP consecutive cycles after at least one valid dibit; frame_done pulses on the cycle after the IDLE_GAP-th invalid cycle.
REQ-015 SHALL reset the gap counter on any valid dibit.
REQ-016 SHALL, at frame close with 1..3 dibits pending, discard them, pulse err, and never emit the partial byte.
REQ-017 SHALL use a saturating per-frame byte counter of width $clog2(MAX_BYTES+1).
REQ-018 SHALL suppress axiov for bytes beyond MAX_BYTES and pulse err at frame close.
REQ-019 SHALL use the states:
- IDLE: no frame in progress.
- HUNT: present only with the macro of REQ-025.
- COLLECT: assembling bytes.
REQ-020 SHALL implement these transitions:
- IDLE->COLLECT (or IDLE->HUNT with the macro) on the first valid dibit; that dibit is consumed.
- COLLECT->IDLE on frame close.
- HUNT->IDLE on frame close, with err.
REQ-021 SHALL, when the fourth dibit and frame-close conditions cannot coincide because a dibit resets the gap, need no tie-break; a byte completing on cycle N is emitted before any close.
REQ-022 SHALL accept a new frame's first dibit on the same cycle that frame_done pulses, with no dead cycle.

Reset
REQ-023 SHALL, while rst is low, force axiov=0, axiod=8'h00, frame_done=0, err=0, state=IDLE, and clear the dibit count, gap counter and byte counter, asynchronously.
REQ-024 SHALL, on reset asserted mid-byte, discard pending dibits; the first valid dibit after release SHALL be d0 of a new byte.

Configuration
REQ-025 SHALL, with BITORDER_IN_SFD_STRIP_EN defined, enter HUNT on the first valid dibit and keep a shift register of the last four dibits.
REQ-026 SHALL, in HUNT, move to COLLECT with the dibit count cleared when that register equals the SFD 8'hD5 (dibits 01,01,01,11); no preamble or SFD byte is emitted.
REQ-027 SHALL, without BITORDER_IN_SFD_STRIP_EN, omit HUNT and emit every byte from the first valid dibit, including preamble and SFD.

Structure
REQ-028 SHALL take the state enum, SFD constant 8'hD5 and preamble dibit 2'b01 from shared package bitorder_pkg.
REQ-029 SHALL be implemented as a single module with no sub-module; the gap counter and byte counter are inline.

Verification
REQ-030 SHALL verify: dibits 11,00,11,11,10,01,10,00 continuous -> axiov pulses with 0xF3, then 0x26, each one cycle after its fourth dibit -> frame_done 5 cycles after the last dibit, err=0.
REQ-031 SHALL verify: dibits 00,00, one invalid cycle, 00,00 -> single byte 0x00, no frame_done during the stall, err=0.
REQ-032 SHALL verify: three dibits, then axiiv low for 4 cycles -> no axiov; frame_done and err pulse together.
REQ-033 SHALL verify: 28 dibits of 01, then 01,01,01,11, then 11,10,10,10 -> 0xAB only with the macro; without it 0x55 x7, 0xD5, 0xAB.
REQ-034 SHALL verify: two dibits, rst low for 1 cycle mid-clock, then dibits 01,00,00,00 -> all outputs 0 during reset, then one byte 0x01.
REQ-035 SHALL verify: MAX_BYTES=4, six 0x11 bytes -> exactly four axiov pulses; err with frame_done at close.

Source files
------------

// File: rtl/bitorder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bitorder_pkg
// Description : Shared types and constants for the dibit-to-byte receive
//               path: FSM state encoding, Ethernet SFD byte and preamble
//               dibit.
// Revision    : 1.0 - initial release
// ============================================================================
package bitorder_pkg;

  // Receive framing states; HUNT is only reachable when SFD stripping is built in
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    COLLECT = 2'd2
  } state_t;

  // Start-of-frame delimiter as an assembled byte (dibits 01,01,01,11 LSB-first)
  localparam logic [7:0] c_sfd            = 8'hD5;

  // Dibit repeated throughout the preamble
  localparam logic [1:0] c_preamble_dibit = 2'b01;

endpackage : bitorder_pkg
`default_nettype wire

// File: rtl/bitorder_in.sv
`default_nettype none
// ============================================================================
// Module      : bitorder_in
// Description : Assembles LSB-first receive dibits into bytes, closes a frame
//               after IDLE_GAP consecutive invalid cycles, flags truncated or
//               oversized frames. Optional macro BITORDER_IN_SFD_STRIP_EN adds
//               a HUNT state that discards the preamble and SFD.
// Revision    : 1.0 - initial release
// ============================================================================
module bitorder_in
  import bitorder_pkg::*;
#(
  parameter int IDLE_GAP  = 4,
  parameter int MAX_BYTES = 1522
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiov,
  output logic [7:0] axiod,
  output logic       frame_done,
  output logic       err
);

  localparam int              c_bw        = $clog2(MAX_BYTES + 1);
  localparam logic [c_bw-1:0] c_max_bytes = c_bw'(MAX_BYTES);
  localparam logic [3:0]      c_gap_last  = 4'(IDLE_GAP - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [1:0]      r_cnt;     // dibits already held for the current byte
  logic [5:0]      r_part;    // up to three pending dibits, newest at the top
  logic [3:0]      r_gap;     // consecutive invalid cycles inside a frame
  logic [c_bw-1:0] r_bytes;   // saturating count of bytes emitted this frame
  logic            r_ovf;     // a byte beyond MAX_BYTES was dropped this frame

  logic            w_active;
  logic            w_take;
  logic            w_close;
  logic            w_byte;
  logic            w_emit;
  logic            w_err;

`ifdef BITORDER_IN_SFD_STRIP_EN
  logic [7:0]      r_sfd;     // last four dibits seen while hunting
  logic            w_sfd_hit;
`endif

  // Decode per-cycle events: dibit acceptance, byte completion, frame close
  always_comb begin
    w_active  = (r_state != IDLE);
    w_close   = w_active && !axiiv && (r_gap == c_gap_last);
`ifdef BITORDER_IN_SFD_STRIP_EN
    w_take    = axiiv && (r_state == COLLECT);
    w_sfd_hit = axiiv && (r_state == HUNT) && ({axiid, r_sfd[7:2]} == c_sfd);
    w_err     = w_close && ((r_cnt != 2'd0) || r_ovf || (r_state == HUNT));
`else
    // The frame's opening dibit is already d0 of the first byte
    w_take    = axiiv && ((r_state == IDLE) || (r_state == COLLECT));
    w_err     = w_close && ((r_cnt != 2'd0) || r_ovf);
`endif
    w_byte    = w_take && (r_cnt == 2'd3);
    w_emit    = w_byte && (r_bytes != c_max_bytes);
  end

  // Next-state selection for the framing FSM
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (axiiv) begin
`ifdef BITORDER_IN_SFD_STRIP_EN
          w_state_next = HUNT;
`else
          w_state_next = COLLECT;
`endif
        end
      end
`ifdef BITORDER_IN_SFD_STRIP_EN
      HUNT: begin
        if (w_close) begin
          w_state_next = IDLE;
        end else if (w_sfd_hit) begin
          w_state_next = COLLECT;
        end
      end
`endif
      COLLECT: begin
        if (w_close) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Framing state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Gap counter, dibit assembly and per-frame byte accounting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gap   <= 4'd0;
      r_cnt   <= 2'd0;
      r_part  <= 6'd0;
      r_bytes <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (axiiv || w_close) begin
        r_gap <= 4'd0;
      end else if (w_active) begin
        r_gap <= r_gap + 4'd1;
      end

      if (w_close) begin
        r_cnt <= 2'd0;
      end else if (w_take) begin
        r_cnt  <= r_cnt + 2'd1;
        r_part <= {axiid, r_part[5:2]};
      end

      if (w_close) begin
        r_bytes <= '0;
        r_ovf   <= 1'b0;
      end else if (w_byte) begin
        if (r_bytes == c_max_bytes) begin
          r_ovf <= 1'b1;
        end else begin
          r_bytes <= r_bytes + c_bw'(1);
        end
      end
    end
  end

`ifdef BITORDER_IN_SFD_STRIP_EN
  // Sliding window of the last four dibits, used only to spot the SFD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sfd <= 8'd0;
    end else if (w_close) begin
      r_sfd <= 8'd0;
    end else if (axiiv && ((r_state == IDLE) || (r_state == HUNT))) begin
      r_sfd <= {axiid, r_sfd[7:2]};
    end
  end
`endif

  // Registered outputs: byte strobe/data, frame close and error pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      axiov      <= 1'b0;
      axiod      <= 8'h00;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      axiov      <= w_emit;
      frame_done <= w_close;
      err        <= w_err;
      if (w_emit) begin
        axiod <= {axiid, r_part};
      end
    end
  end

endmodule : bitorder_in
`default_nettype wire
